seq_det_param: RTL and testbench

- Parametrised, runtime-programmable serial bit-pattern detector; next generation of the fixed "110" detector.
- Pattern length is a parameter and the pattern value is loaded at runtime.
- Selectable overlapping or non-overlapping match mode; input is valid-qualified.
- Provides a registered match pulse and a saturating match counter; sits between a serial bit source and status/interrupt logic.

---
 rtl/seq_det_param_pkg.sv | 22 ++
 rtl/seq_det_param_sat_counter.sv | 40 ++++
 rtl/seq_det_param.sv | 87 ++++++++
 tb/tb_seq_det_param.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_param_pkg.sv
// ============================================================================
// Module   : seq_det_param_pkg
// Brief    : Shared constants and helpers for the serial pattern detector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_det_param_pkg;

  localparam int   C_DEF_PAT_W     = 3;
  localparam int   C_DEF_CNT_W     = 8;
  localparam logic MODE_OVERLAP    = 1'b1;
  localparam logic MODE_NONOVERLAP = 1'b0;

  // Width needed to hold a fill count ranging over 0..pat_w inclusive.
  function automatic int fill_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_det_param_sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Brief    : Saturating event counter with sticky overflow; clear beats inc.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (inc) begin
      if (&r_count) begin
        r_overflow <= 1'b1;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: rtl/seq_det_param.sv
// ============================================================================
// Module   : seq_det_param
// Brief    : Runtime-programmable serial bit-pattern detector with counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_det_param
  import seq_det_param_pkg::*;
#(
  parameter int PAT_W = C_DEF_PAT_W,
  parameter int CNT_W = C_DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             clr_count,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             overflow
);

  localparam int                FILL_W      = fill_width(PAT_W);
  localparam logic [FILL_W-1:0] C_FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] C_FILL_ARM  = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  r_pattern;
  logic              r_overlap;
  // Only PAT_W-1 bits are kept: the oldest bit would shift out before it
  // could ever take part in a comparison.
  logic [PAT_W-2:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic              r_match;

  logic [PAT_W-1:0]  w_cand;
  logic              w_match;

  assign w_cand  = {r_hist, in_bit};
  assign w_match = in_valid && !cfg_load && (r_fill >= C_FILL_ARM) &&
                   (w_cand == r_pattern);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pattern <= '0;
      r_overlap <= MODE_OVERLAP;
      r_hist    <= '0;
      r_fill    <= '0;
      r_match   <= 1'b0;
    end else if (cfg_load) begin
      r_pattern <= cfg_pattern;
      r_overlap <= cfg_overlap;
      r_hist    <= '0;
      r_fill    <= '0;
      r_match   <= 1'b0;
    end else begin
      r_match <= w_match;
      if (in_valid) begin
        r_hist <= w_cand[PAT_W-2:0];
        if (w_match && (r_overlap == MODE_NONOVERLAP)) begin
          r_fill <= '0;
        end else if (r_fill != C_FILL_FULL) begin
          r_fill <= r_fill + FILL_W'(1);
        end
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_sat_counter (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_match),
    .clr      (clr_count),
    .count    (match_count),
    .overflow (overflow)
  );

  assign match = r_match;

endmodule

`default_nettype wire

// File: tb/tb_seq_det_param.sv
// ============================================================================
// Module   : tb_seq_det_param
// Brief    : Directed and random stimulus against a behavioural detector model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_det_param;

  logic       clk = 1'b0;
  logic       rst, cfg_load, cfg_overlap, clr_count, in_valid, in_bit;
  logic [2:0] cfg_pattern;

  logic       match_a, ovf_a, match_b, ovf_b, match_s, ovf_s;
  logic [7:0] count_a, count_b;
  logic [1:0] count_s;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: index 0 = 3-bit pattern detector, index 1 = 2-bit detector.
  int m_hist[2], m_fill[2], m_pat[2], m_ov[2], m_n[2], m_match[2];
  int pulses[2];

  always #5 clk = ~clk;

  seq_det_param #(.PAT_W(3), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap), .clr_count(clr_count), .in_valid(in_valid),
    .in_bit(in_bit), .match(match_a), .match_count(count_a), .overflow(ovf_a));

  seq_det_param #(.PAT_W(2), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern[1:0]),
    .cfg_overlap(cfg_overlap), .clr_count(clr_count), .in_valid(in_valid),
    .in_bit(in_bit), .match(match_b), .match_count(count_b), .overflow(ovf_b));

  seq_det_param #(.PAT_W(3), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap), .clr_count(clr_count), .in_valid(in_valid),
    .in_bit(in_bit), .match(match_s), .match_count(count_s), .overflow(ovf_s));

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int n, input int w);
    int top = (1 << w) - 1;
    return (n > top) ? top : n;
  endfunction

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      int w    = (k == 0) ? 3 : 2;
      int mask = (1 << w) - 1;
      int m    = 0;
      if (rst) begin
        m_hist[k] = 0; m_fill[k] = 0; m_pat[k] = 0; m_ov[k] = 1;
        m_n[k] = 0; m_match[k] = 0;
      end else if (cfg_load) begin
        m_pat[k] = int'(cfg_pattern) & mask;
        m_ov[k] = int'(cfg_overlap);
        m_hist[k] = 0; m_fill[k] = 0; m_match[k] = 0;
        if (clr_count) m_n[k] = 0;
      end else begin
        if (in_valid) begin
          m_hist[k] = ((m_hist[k] << 1) | int'(in_bit)) & mask;
          m = (m_fill[k] >= w - 1 && m_hist[k] == m_pat[k]) ? 1 : 0;
          m_fill[k] = (m_fill[k] < w) ? m_fill[k] + 1 : w;
          if (m == 1 && m_ov[k] == 0) m_fill[k] = 0;
        end
        m_match[k] = m;
        if (clr_count) m_n[k] = 0;
        else if (m == 1) m_n[k]++;
      end
    end
  endtask

  task automatic compare_all();
    check("match_a", int'(match_a), m_match[0]);
    check("count_a", int'(count_a), sat(m_n[0], 8));
    check("ovf_a",   int'(ovf_a),   (m_n[0] > 255) ? 1 : 0);
    check("match_b", int'(match_b), m_match[1]);
    check("count_b", int'(count_b), sat(m_n[1], 8));
    check("ovf_b",   int'(ovf_b),   (m_n[1] > 255) ? 1 : 0);
    check("match_s", int'(match_s), m_match[0]);
    check("count_s", int'(count_s), sat(m_n[0], 2));
    check("ovf_s",   int'(ovf_s),   (m_n[0] > 3) ? 1 : 0);
    if (match_a) pulses[0]++;
    if (match_b) pulses[1]++;
  endtask

  task automatic step(input logic r, input logic ld, input logic [2:0] pat,
                      input logic ov, input logic clr, input logic v, input logic b);
    rst = r; cfg_load = ld; cfg_pattern = pat; cfg_overlap = ov;
    clr_count = clr; in_valid = v; in_bit = b;
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic feed(input logic b);
    step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, b);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [2:0] pat, input logic ov);
    step(1'b0, 1'b1, pat, ov, 1'b1, 1'b0, 1'b0);
    pulses[0] = 0;
    pulses[1] = 0;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_match", int'(match_a), 0);
    check("rst_count", int'(count_a), 0);
  endtask

  initial begin
    logic [31:0] stream;
    rst = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_overlap = 1'b0;
    clr_count = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    do_reset();
    do_reset();

    // Long stream, overlapping 110
    load(3'b110, 1'b1);
    stream = 32'b11011001011011001101100110110100;
    for (int i = 31; i >= 0; i--) feed(stream[i]);
    idle();
    check("t1_pulses", pulses[0], 8);
    check("t1_count", int'(count_a), 8);

    // 101 over 10101 in both modes
    load(3'b101, 1'b1);
    feed(1); feed(0); feed(1); feed(0); feed(1); idle();
    check("t2_ov_pulses", pulses[0], 2);
    check("t2_ov_count", int'(count_a), 2);
    load(3'b101, 1'b0);
    feed(1); feed(0); feed(1); feed(0); feed(1); idle();
    check("t2_nov_pulses", pulses[0], 1);
    check("t2_nov_count", int'(count_a), 1);

    // Two-bit pattern 11 over 1111
    load(3'b011, 1'b1);
    for (int i = 0; i < 4; i++) feed(1);
    idle();
    check("t2_11_ov", pulses[1], 3);
    load(3'b011, 1'b0);
    for (int i = 0; i < 4; i++) feed(1);
    idle();
    check("t2_11_nov", pulses[1], 2);

    // Gapped input
    load(3'b110, 1'b1);
    feed(1); idle(); idle(); idle();
    feed(1); idle(); idle(); idle();
    feed(0);
    check("t3_gap_pulse", int'(match_a), 1);
    idle();
    check("t3_gap_total", pulses[0], 1);

    // Pattern 000 after reset: no match before the third zero
    do_reset();
    feed(0); feed(0);
    check("t3_zero_early", int'(match_a), 0);
    feed(0);
    check("t3_zero_third", int'(match_a), 1);

    // Saturation of the narrow counter, then clear
    load(3'b111, 1'b1);
    for (int i = 0; i < 10; i++) feed(1);
    check("t4_sat_count", int'(count_s), 3);
    check("t4_sat_ovf", int'(ovf_s), 1);
    step(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t4_clr_count", int'(count_s), 0);
    check("t4_clr_ovf", int'(ovf_s), 0);
    step(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1);
    check("t4_clrmatch_pulse", int'(match_s), 1);
    check("t4_clrmatch_count", int'(count_s), 0);

    // Reset mid-stream, then cfg_load colliding with a completing bit
    load(3'b110, 1'b1);
    feed(1); feed(1);
    do_reset();
    feed(0);
    check("t5_rst_nomatch", int'(match_a), 0);
    load(3'b110, 1'b1);
    feed(1); feed(1);
    step(1'b0, 1'b1, 3'b110, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t5_ld_nomatch", int'(match_a), 0);
    feed(0);
    check("t5_ld_restart", int'(match_a), 0);
    feed(1); feed(1); feed(0);
    check("t5_ld_then_match", int'(match_a), 1);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom % 300) == 0, ($urandom % 60) == 0, 3'($urandom),
           1'($urandom), ($urandom % 80) == 0, ($urandom % 4) != 0, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
